// File: rtl/fsm_state_monitor.sv
// ---------------------------------------------------------------------------
// fsm_state_monitor
//
// Passive observer on the 2-bit state bus of a Moore FSM (y1 = MSB, y2 = LSB).
// It never drives the FSM. Every enabled clock it samples the state and
// presents it one-hot. It counts state changes, measures how long the current
// state has been held, and flags and captures the first transition that the
// LEGAL_MASK parameter does not allow.
//
// Parameters
//   LEGAL_MASK  bit (from*4 + to) = 1 marks from->to as legal
//   CNT_W       width of the saturating transition counter
//   DWELL_W     width of the saturating dwell counter
//
// Ports
//   inputClk          clock, rising edge
//   inputR            asynchronous active-high reset
//   inputY1/inputY2   state bits from the FSM flip-flop stage
//   inputEn           sample enable; 0 freezes every register except the
//                     error clear path
//   inputClrErr       synchronous clear of the sticky error and its capture
//   outputValid       a first sample has been taken since reset
//   outputState       one-hot copy of the last sample; zero until valid
//   outputTransCount  saturating count of state changes
//   outputDwell       saturating count of repeated samples
//   outputError       sticky illegal-transition flag
//   outputErrFrom/To  pair captured at the first illegal transition
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module fsm_state_monitor #(
    parameter logic [15:0] LEGAL_MASK = 16'h9C63,
    parameter int          CNT_W      = 8,
    parameter int          DWELL_W    = 8
) (
    input  logic               inputClk,
    input  logic               inputR,
    input  logic               inputY1,
    input  logic               inputY2,
    input  logic               inputEn,
    input  logic               inputClrErr,
    output logic               outputValid,
    output logic [3:0]         outputState,
    output logic [CNT_W-1:0]   outputTransCount,
    output logic [DWELL_W-1:0] outputDwell,
    output logic               outputError,
    output logic [1:0]         outputErrFrom,
    output logic [1:0]         outputErrTo
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] oh;
        oh    = 4'b0000;
        oh[s] = 1'b1;
        return oh;
    endfunction

    // Registered state
    logic [1:0]         prev_q,   prev_d;
    logic               valid_q,  valid_d;
    logic [3:0]         oh_q,     oh_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic               err_q,    err_d;
    logic [1:0]         efrom_q,  efrom_d;
    logic [1:0]         eto_q,    eto_d;

    logic [1:0] cur;
    logic       changed;
    logic       illegal;

    assign cur     = {inputY1, inputY2};
    assign changed = (cur != prev_q);
    // Only meaningful once a previous sample exists and sampling is enabled.
    assign illegal = inputEn && valid_q && !LEGAL_MASK[{prev_q, cur}];

    // Sampling, counting and dwell
    always_comb begin
        prev_d  = prev_q;
        valid_d = valid_q;
        oh_d    = oh_q;
        count_d = count_q;
        dwell_d = dwell_q;

        if (inputEn) begin
            prev_d = cur;
            oh_d   = onehot(cur);
            if (!valid_q) begin
                // First sample only establishes the reference state.
                valid_d = 1'b1;
                dwell_d = '0;
            end else if (changed) begin
                if (count_q != CNT_MAX)
                    count_d = count_q + CNT_W'(1);
                dwell_d = '0;
            end else begin
                // An illegal self-loop lands here too: dwell grows, count does not.
                if (dwell_q != DWELL_MAX)
                    dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // Sticky error and first-offender capture
    always_comb begin
        err_d   = err_q;
        efrom_d = efrom_q;
        eto_d   = eto_q;

        if (inputClrErr) begin
            err_d   = 1'b0;
            efrom_d = 2'd0;
            eto_d   = 2'd0;
        end

        // Detection overrides a same-edge clear; a clear re-arms the capture,
        // so the pair seen on that edge becomes the new first offender.
        if (illegal) begin
            err_d = 1'b1;
            if (!err_q || inputClrErr) begin
                efrom_d = prev_q;
                eto_d   = cur;
            end
        end
    end

    always_ff @(posedge inputClk or posedge inputR) begin
        if (inputR) begin
            prev_q  <= 2'd0;
            valid_q <= 1'b0;
            oh_q    <= 4'b0000;
            count_q <= '0;
            dwell_q <= '0;
            err_q   <= 1'b0;
            efrom_q <= 2'd0;
            eto_q   <= 2'd0;
        end else begin
            prev_q  <= prev_d;
            valid_q <= valid_d;
            oh_q    <= oh_d;
            count_q <= count_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            efrom_q <= efrom_d;
            eto_q   <= eto_d;
        end
    end

    assign outputValid      = valid_q;
    assign outputState      = oh_q;
    assign outputTransCount = count_q;
    assign outputDwell      = dwell_q;
    assign outputError      = err_q;
    assign outputErrFrom    = efrom_q;
    assign outputErrTo      = eto_q;

endmodule

// File: doc/fsm_state_monitor.md
# fsm_state_monitor

Passive reader on the 2-bit state bus driven by the Moore FSM's flip-flop stage (y1 = MSB, y2 = LSB).
- Samples the state every enabled clock and presents it decoded one-hot.
- Counts state changes and measures dwell time in the current state.
- Flags the first transition not allowed by a configurable legality mask, and captures it.
- Sits beside the FSM in lab top-levels and benches as a bring-up and debug observer. It never drives the FSM.

## Interface
Parameters:
- LEGAL_MASK, 16'h9C63: bit (from*4 + to) = 1 marks from→to as legal. Default allows self-loops and 00→01→10→11→00.
- CNT_W, 8: width of the transition counter.
- DWELL_W, 8: width of the dwell counter.

Ports:
- inputClk  in  1  single clock; all state updates on its rising edge.
- inputR  in  1  reset, asynchronous, active-high.
- inputY1  in  1  state bit y1 (MSB) from the FSM flip-flop stage.
- inputY2  in  1  state bit y2 (LSB).
- inputEn  in  1  sample enable; 0 freezes all internal state.
- inputClrErr  in  1  synchronous clear of the sticky error and its capture.
- outputValid  out  1  high once a first sample has been taken since reset.
- outputState  out  4  one-hot copy of the last sample: bit k set when state == k. All zeros while outputValid = 0.
- outputTransCount  out  CNT_W  saturating count of state changes.
- outputDwell  out  DWELL_W  saturating count of consecutive enabled samples equal to the previous one.
- outputError  out  1  sticky illegal-transition flag.
- outputErrFrom  out  2  "from" state of the first illegal transition.
- outputErrTo  out  2  "to" state of the first illegal transition.

## Operation
- Internal registers: prev[1:0], valid, count, dwell, err, errFrom, errTo. All outputs are registered.
- Reset (inputR = 1, async): all registers cleared to 0, so every output reads 0. Takes effect immediately, including in the middle of a sequence.
- Each rising edge with inputEn = 1, cur = {inputY1, inputY2}:
  - valid = 0 (first sample): prev ← cur, valid ← 1, dwell ← 0. No count update, no legality check.
  - valid = 1 and cur ≠ prev: count ← count+1, holding at 2^CNT_W−1. dwell ← 0.
  - valid = 1 and cur = prev: dwell ← dwell+1, holding at 2^DWELL_W−1. Count unchanged.
  - valid = 1 and LEGAL_MASK[prev*4+cur] = 0: err ← 1. If err was 0, also errFrom ← prev and errTo ← cur. Later illegal transitions do not overwrite the capture.
  - prev ← cur in every valid = 1 case.
- inputEn = 0: all registers hold. A state change while disabled is seen as a single prev→cur jump at the next enabled sample, and is checked against the mask.
- inputClrErr = 1 on an edge: err, errFrom and errTo are cleared to 0.
  - If the same edge also detects an illegal transition, detection wins: err = 1 and the new pair is captured.
  - inputClrErr acts regardless of inputEn. It does not affect count, dwell or valid.
- An illegal self-loop (mask bit cleared for k→k) sets the error but does not increment count; dwell still increments.

## Timing
- Latency is one clock: a value on inputY1/inputY2 before edge N is reflected on every output after edge N.
- No combinational path from any input to any output.
- Reset is asserted asynchronously. On release, the first enabled edge only sets outputValid and outputState. Transitions can be counted from the second enabled edge onward.
- No handshake. Inputs must be stable around the rising edge, which holds because they come from the same-clock flip-flop stage.

## Test plan
- Reset values: assert inputR mid-run with count = 3 and err = 1 → all outputs 0 immediately. After release with inputEn = 1 and state 00: outputValid = 1 and outputState = 4'b0001 after one edge.
- Legal cycle: drive 00, 01, 10, 11, 00 on consecutive enabled edges → outputTransCount = 4, outputError = 0, outputDwell = 0, final outputState = 4'b0001.
- Illegal transition: 00 then 10 → outputError = 1, outputErrFrom = 0, outputErrTo = 2 one edge after the 10 sample. A following illegal 10→00 leaves errFrom = 0 and errTo = 2 unchanged.
- Saturation: DWELL_W = 4 with state held at 11 for 20 enabled edges → outputDwell = 15. CNT_W = 2 with 5 legal changes → outputTransCount = 3.
- Clear vs detect: inputClrErr = 1 on the same edge as an illegal 01→11 → outputError = 1, errFrom = 1, errTo = 3. inputClrErr alone on the next edge → outputError = 0, errFrom = 0, errTo = 0.
- Enable gating: inputEn = 0 while the state moves 00→01→10 → outputs frozen. On re-enable with state 10: the 00→10 jump is flagged illegal and count increments by 1.
